// File: rtl/led_seq_ctrl.sv
// Four-LED chaser: a run/pause FSM gates a prescaler that steps a one-hot
// pattern left or right, in ring (wrap-around) or bounce (reflect) mode.
module led_seq_ctrl #(
    parameter logic [25:0] TICK_DIV = 26'd50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run_p,
    input  logic       left_p,
    input  logic       right_p,
    input  logic       speed_p,
    input  logic       mode_p,
    output logic [3:0] led,
    output logic       running,
    output logic       dir,
    output logic [1:0] speed,
    output logic       bounce,
    output logic       tick
);

    typedef enum logic {
        ST_PAUSE = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [25:0] cnt_q, cnt_d;
    logic [25:0] period_s;
    logic [3:0]  led_q, led_d;
    logic        dir_q, dir_d;
    logic [1:0]  speed_q, speed_d;
    logic        bounce_q, bounce_d;
    logic        tick_q, tick_d;
    logic        step_s;
    logic        reflect_s;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

    assign period_s = TICK_DIV >> speed_q;

    // State, prescaler and pattern registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_PAUSE;
            cnt_q    <= 26'd0;
            led_q    <= 4'b0001;
            dir_q    <= 1'b0;
            speed_q  <= 2'd0;
            bounce_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            led_q    <= led_d;
            dir_q    <= dir_d;
            speed_q  <= speed_d;
            bounce_q <= bounce_d;
            tick_q   <= tick_d;
        end
    end

    // Run/pause FSM and prescaler; a run or speed pulse pre-empts a due step
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_s  = 1'b0;
        case (state_q)
            ST_PAUSE: begin
                cnt_d = 26'd0;
                if (run_p) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_RUN: begin
                if (run_p) begin
                    state_d = ST_PAUSE;
                    cnt_d   = 26'd0;
                end else if (speed_p) begin
                    cnt_d = 26'd0;
                end else if (cnt_q == (period_s - 26'd1)) begin
                    cnt_d  = 26'd0;
                    step_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + 26'd1;
                end
            end
            default: begin
                state_d = ST_PAUSE;
                cnt_d   = 26'd0;
            end
        endcase
    end

    // Pattern step; a corrupted pattern is forced back to LED0
    always_comb begin
        led_d     = led_q;
        reflect_s = 1'b0;
        if (!is_onehot(led_q)) begin
            led_d = 4'b0001;
        end else if (step_s) begin
            if (dir_q) begin
                if (led_q == 4'b1000) begin
                    if (bounce_q) begin
                        led_d     = 4'b0100;
                        reflect_s = 1'b1;
                    end else begin
                        led_d = 4'b0001;
                    end
                end else begin
                    led_d = led_q << 1;
                end
            end else begin
                if (led_q == 4'b0001) begin
                    if (bounce_q) begin
                        led_d     = 4'b0010;
                        reflect_s = 1'b1;
                    end else begin
                        led_d = 4'b1000;
                    end
                end else begin
                    led_d = led_q >> 1;
                end
            end
        end else begin
            led_d = led_q;
        end
    end

    // Direction: explicit pulses override a bounce reflection on the same edge
    always_comb begin
        dir_d = dir_q;
        if (left_p && right_p) begin
            dir_d = ~dir_q;
        end else if (left_p) begin
            dir_d = 1'b1;
        end else if (right_p) begin
            dir_d = 1'b0;
        end else if (reflect_s) begin
            dir_d = ~dir_q;
        end else begin
            dir_d = dir_q;
        end
    end

    // Speed level, mode and the step-visible pulse
    always_comb begin
        speed_d  = speed_q;
        bounce_d = bounce_q ^ mode_p;
        tick_d   = step_s;
        if (speed_p) begin
            speed_d = speed_q + 2'd1;
        end else begin
            speed_d = speed_q;
        end
    end

    assign led     = led_q;
    assign running = (state_q == ST_RUN);
    assign dir     = dir_q;
    assign speed   = speed_q;
    assign bounce  = bounce_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl (TICK_DIV=16) against a position-based
// reference model plus directed scenarios.
module tb_led_seq_ctrl;

    localparam int DIV = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run_p = 1'b0, left_p = 1'b0, right_p = 1'b0, speed_p = 1'b0, mode_p = 1'b0;
    logic [3:0] led;
    logic       running, dir, bounce, tick;
    logic [1:0] speed;
    logic [9:0] dut_vec;

    int checks = 0;
    int errors = 0;

    // reference model: LED position 0..3 and cycles elapsed in the current period
    int m_pos, m_elapsed, m_speed;
    bit m_run, m_dir, m_bounce, m_tick;

    localparam logic [9:0] RESET_VEC = {4'b0001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};

    led_seq_ctrl #(.TICK_DIV(26'd16)) dut (
        .clk(clk), .rst_n(rst_n), .run_p(run_p), .left_p(left_p), .right_p(right_p),
        .speed_p(speed_p), .mode_p(mode_p), .led(led), .running(running), .dir(dir),
        .speed(speed), .bounce(bounce), .tick(tick)
    );

    always #5 clk = ~clk;

    assign dut_vec = {led, running, dir, speed, bounce, tick};

    function automatic logic [9:0] exp_vec();
        logic [3:0] l;
        l = 4'b0001 << m_pos;
        return {l, m_run, m_dir, 2'(m_speed), m_bounce, m_tick};
    endfunction

    task automatic model_reset();
        m_pos = 0; m_elapsed = 0; m_speed = 0;
        m_run = 1'b0; m_dir = 1'b0; m_bounce = 1'b0; m_tick = 1'b0;
    endtask

    task automatic model_edge(input bit r, input bit l, input bit rt, input bit s, input bit m);
        bit stp;
        bit reflect;
        stp = 1'b0;
        reflect = 1'b0;
        if (m_run) begin
            if (r || s) m_elapsed = 0;
            else if (m_elapsed + 1 == (DIV >> m_speed)) begin stp = 1'b1; m_elapsed = 0; end
            else m_elapsed = m_elapsed + 1;
        end
        if (stp) begin
            if (m_bounce && m_dir && m_pos == 3) begin m_pos = 2; reflect = 1'b1; end
            else if (m_bounce && !m_dir && m_pos == 0) begin m_pos = 1; reflect = 1'b1; end
            else m_pos = m_dir ? (m_pos + 1) % 4 : (m_pos + 3) % 4;
        end
        if (l && rt) m_dir = !m_dir;
        else if (l) m_dir = 1'b1;
        else if (rt) m_dir = 1'b0;
        else if (reflect) m_dir = !m_dir;
        if (s) m_speed = (m_speed + 1) % 4;
        m_bounce = m_bounce ^ m;
        m_run = m_run ^ r;
        m_tick = stp;
    endtask

    // one clock with the given pulses; leaves time at posedge+1
    task automatic drive(input bit r, input bit l, input bit rt, input bit s, input bit m);
        run_p = r; left_p = l; right_p = rt; speed_p = s; mode_p = m;
        @(posedge clk);
        model_edge(r, l, rt, s, m);
        #1;
        run_p = 1'b0; left_p = 1'b0; right_p = 1'b0; speed_p = 1'b0; mode_p = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        model_reset();
        #23;
        checks++;
        if (dut_vec !== RESET_VEC) begin
            errors++; $display("FAIL reset_values: got %b expected %b", dut_vec, RESET_VEC);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            drive(0, 0, 0, 0, 0);
            checks++;
            if (dut_vec !== RESET_VEC) begin
                errors++; $display("FAIL idle_after_reset cycle %0d: got %b expected %b", i, dut_vec, RESET_VEC);
            end
        end
    endtask

    task automatic test_ring_right();
        logic [3:0] seq [4];
        seq = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        apply_reset();
        drive(1, 0, 0, 0, 0);
        for (int j = 1; j <= 64; j++) begin
            drive(0, 0, 0, 0, 0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL ring_right_model j=%0d: got %b expected %b", j, dut_vec, exp_vec());
            end
            if (j % 16 == 0) begin
                checks++;
                if (led !== seq[j/16-1] || tick !== 1'b1) begin
                    errors++; $display("FAIL ring_right_step j=%0d: got led %b tick %b expected led %b tick 1", j, led, tick, seq[j/16-1]);
                end
            end else begin
                checks++;
                if (tick !== 1'b0) begin
                    errors++; $display("FAIL ring_right_notick j=%0d: got tick %b expected 0", j, tick);
                end
            end
        end
    endtask

    task automatic test_speed();
        apply_reset();
        drive(1, 0, 0, 0, 0);
        repeat (5) drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        for (int j = 1; j <= 40; j++) begin
            drive(0, 0, 0, 0, 0);
            checks++;
            if (tick !== 1'(j % 8 == 0) || dut_vec !== exp_vec()) begin
                errors++; $display("FAIL speed1_period j=%0d: got %b expected %b", j, dut_vec, exp_vec());
            end
        end
        repeat (3) drive(0, 0, 0, 1, 0);
        checks++;
        if (speed !== 2'd0) begin
            errors++; $display("FAIL speed_wrap: got %0d expected 0", speed);
        end
        for (int j = 1; j <= 48; j++) begin
            drive(0, 0, 0, 0, 0);
            checks++;
            if (tick !== 1'(j % 16 == 0) || dut_vec !== exp_vec()) begin
                errors++; $display("FAIL speed0_period j=%0d: got %b expected %b", j, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] want [7];
        logic [3:0] got [$];
        want = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        apply_reset();
        drive(0, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        for (int j = 1; j <= 7 * DIV; j++) begin
            drive(0, 0, 0, 0, 0);
            if (tick === 1'b1) got.push_back(led);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL bounce_model j=%0d: got %b expected %b", j, dut_vec, exp_vec());
            end
        end
        checks++;
        if (got.size() != 7) begin
            errors++; $display("FAIL bounce_count: got %0d steps expected 7", got.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (got[i] !== want[i]) begin
                    errors++; $display("FAIL bounce_seq step %0d: got %b expected %b", i, got[i], want[i]);
                end
            end
        end
        checks++;
        if (dir !== 1'b1) begin
            errors++; $display("FAIL bounce_final_dir: got %b expected 1", dir);
        end
    endtask

    task automatic test_both_dir();
        apply_reset();
        drive(0, 1, 1, 0, 0);
        checks++;
        if (dir !== 1'b1 || led !== 4'b0001 || running !== 1'b0) begin
            errors++; $display("FAIL both_dir_1: got dir %b led %b run %b expected 1 0001 0", dir, led, running);
        end
        drive(0, 1, 1, 0, 0);
        checks++;
        if (dir !== 1'b0 || led !== 4'b0001) begin
            errors++; $display("FAIL both_dir_2: got dir %b led %b expected 0 0001", dir, led);
        end
    endtask

    task automatic test_run_on_step();
        apply_reset();
        drive(1, 0, 0, 0, 0);
        repeat (DIV - 1) drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        checks++;
        if (running !== 1'b0 || led !== 4'b0001 || tick !== 1'b0) begin
            errors++; $display("FAIL run_on_step: got run %b led %b tick %b expected 0 0001 0", running, led, tick);
        end
        drive(1, 0, 0, 0, 0);
        repeat (DIV + 7) drive(0, 0, 0, 0, 0);
        drive(0, 1, 0, 1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec !== RESET_VEC) begin
            errors++; $display("FAIL async_reset_midcount: got %b expected %b", dut_vec, RESET_VEC);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (DIV + 4) begin
            drive(0, 0, 0, 0, 0);
            checks++;
            if (dut_vec !== RESET_VEC) begin
                errors++; $display("FAIL pause_after_reset: got %b expected %b", dut_vec, RESET_VEC);
            end
        end
    endtask

    task automatic test_random();
        bit r, l, rt, s, m;
        apply_reset();
        for (int i = 0; i < 4000; i++) begin
            r  = ($urandom_range(59) == 0);
            l  = ($urandom_range(19) == 0);
            rt = ($urandom_range(19) == 0);
            s  = ($urandom_range(39) == 0);
            m  = ($urandom_range(29) == 0);
            drive(r, l, rt, s, m);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL random cycle %0d: got %b expected %b", i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_ring_right();
        test_speed();
        test_bounce();
        test_both_dir();
        test_run_on_step();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 26'd50_000_000, base step period in clk cycles at speed 0; legal range 8..2^26-1.
REQ-002 clk  input  1  system clock, 50 MHz nominal, all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 run_p  input  1  single-cycle pulse from key debouncer; toggles run/pause.
REQ-005 left_p  input  1  single-cycle pulse; request direction left (led[0] toward led[3]).
REQ-006 right_p  input  1  single-cycle pulse; request direction right (led[3] toward led[0]).
REQ-007 speed_p  input  1  single-cycle pulse; advance speed level 0->1->2->3->0.
REQ-008 mode_p  input  1  single-cycle pulse; toggle ring/bounce mode.
REQ-009 led  output  4  one-hot LED pattern, bit n drives LEDn.
REQ-010 running  output  1  1 = FSM in RUN state.
REQ-011 dir  output  1  1 = left, 0 = right.
REQ-012 speed  output  2  current speed level.
REQ-013 bounce  output  1  1 = bounce mode, 0 = ring mode.
REQ-014 tick  output  1  one-cycle pulse, high in the cycle led shows a newly stepped value.

Function
REQ-015 FSM states PAUSE and RUN; run_p in PAUSE -> RUN, run_p in RUN -> PAUSE; no other transitions.
REQ-016 Step period P = TICK_DIV >> speed (clk cycles); 26-bit unsigned, no rounding.
REQ-017 Prescaler cnt: held at 0 in PAUSE; in RUN increments each clk; at cnt == P-1 cnt <= 0, led steps, tick <= 1 on that same edge.
REQ-018 First step after entering RUN at edge k occurs at edge k+P; subsequent steps every P cycles.
REQ-019 speed_p: speed <= speed+1 mod 4, cnt <= 0 on the same edge; no step on that edge.
REQ-020 Left step: led <= led<<1; 4'b1000 wraps to 4'b0001 in ring mode.
REQ-021 Right step: led <= led>>1; 4'b0001 wraps to 4'b1000 in ring mode.
REQ-022 Bounce mode: at 4'b1000 with dir=1, the step flips dir to 0 and sets led 4'b0100; at 4'b0001 with dir=0, it flips dir to 1 and sets led 4'b0010.
REQ-023 left_p alone sets dir=1; right_p alone sets dir=0; both in the same cycle toggle dir.
REQ-024 A step on the same edge as a direction pulse uses the pre-edge dir; the pulse's dir takes effect from the next step.
REQ-025 run_p coincident with a step edge in RUN: PAUSE wins, no step, led unchanged, tick stays 0, cnt <= 0.
REQ-026 speed_p coincident with a would-be step edge: REQ-019 wins, no step.
REQ-027 mode_p toggles bounce immediately, and no step is suppressed.
REQ-028 Direction, speed and mode pulses are accepted in both PAUSE and RUN.
REQ-029 led is always one-hot; if a non-one-hot value is ever detected, led <= 4'b0001 on the next edge.

Reset
REQ-030 While rst_n=0: led=4'b0001, running=0 (PAUSE), dir=0, speed=0, bounce=0, tick=0, cnt=0.
REQ-031 Reset assertion mid-step or mid-count aborts immediately to REQ-030 values.
REQ-032 After deassertion the block stays in PAUSE until run_p.

Verification (TICK_DIV=16)
REQ-033 Reset, no pulses for 200 cycles -> led=0001, tick never asserted, running=0.
REQ-034 run_p at edge k, dir=0 -> led 1000 at k+16, 0100 at k+32, 0010 at k+48, 0001 at k+64; tick high 1 cycle each.
REQ-035 speed_p once while running, then run -> steps every 8 cycles; speed_p 3 more times -> speed=0, period 16.
REQ-036 mode_p, left_p, run_p from led=0001 -> 0010, 0100, 1000, 0100 (dir=0), 0010, 0001, 0010 (dir=1).
REQ-037 left_p and right_p same cycle with dir=0 -> dir=1; again -> dir=0; led unchanged while paused.
REQ-038 run_p on the exact step edge -> running=0, led unchanged, tick=0; rst_n low mid-count -> REQ-030 values at once.
